// File: rtl/iob_clkdiv_if.sv
// Control and status bundle for the iob_clkdiv multi-channel divider.
// The master drives run enables and ratio loads; the slave returns clocks, ticks and busy flags.
interface iob_clkdiv_if #(
   parameter int N_CH  = 2,
   parameter int DIV_W = 8
);
   logic [N_CH-1:0]       en;
   logic [N_CH*DIV_W-1:0] div;
   logic [N_CH-1:0]       div_ld;
   logic [N_CH-1:0]       clk_out;
   logic [N_CH-1:0]       tick;
   logic [N_CH-1:0]       busy;

   modport master (
      output en,
      output div,
      output div_ld,
      input  clk_out,
      input  tick,
      input  busy
   );

   modport slave (
      input  en,
      input  div,
      input  div_ld,
      output clk_out,
      output tick,
      output busy
   );
endinterface

// File: rtl/iob_clkdiv.sv
// N_CH independent glitch-free clock dividers with matching clock-enable ticks; outputs are registered.
// Start latency 1 cycle from en; ratio and stop changes only take effect at a period boundary.
module iob_clkdiv #(
   parameter int N_CH    = 2,
   parameter int DIV_W   = 8,
   parameter int DIV_RST = 2
) (
   input  logic         clk,
   input  logic         rst,
   iob_clkdiv_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [DIV_W-1:0] RST_R = DIV_W'(DIV_RST);
   localparam logic [DIV_W-1:0] MIN_R = DIV_W'(2);
   localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

   logic [N_CH-1:0] clk_v;
   logic [N_CH-1:0] tick_v;
   logic [N_CH-1:0] busy_v;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_q, state_d;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic [DIV_W-1:0] r_q, r_d;
      logic [DIV_W-1:0] p_q, p_d;
      logic [DIV_W-1:0] div_raw, ld_val, hi_d;
      logic             busy_q, busy_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic             wrap, apply;

      assign div_raw = bus.div[gi*DIV_W +: DIV_W];
      assign ld_val  = (div_raw < MIN_R) ? MIN_R : div_raw;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         r_d     = r_q;
         p_d     = p_q;
         busy_d  = busy_q;
         wrap    = (state_q == RUN) && (cnt_q == r_q - ONE);
         // A pending ratio lands only where no period is in flight.
         apply   = busy_q && ((state_q == IDLE) || wrap);

         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (bus.en[gi]) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (wrap) begin
                  cnt_d = '0;
                  if (!bus.en[gi]) begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase

         if (apply) begin
            r_d    = p_q;
            busy_d = 1'b0;
         end
         // A load on the apply edge is captured after the old value moved on.
         if (bus.div_ld[gi]) begin
            p_d    = ld_val;
            busy_d = 1'b1;
         end

         hi_d   = r_d - (r_d >> 1);
         clk_d  = (state_d == RUN) && (cnt_d < hi_d);
         tick_d = (state_d == RUN) && (cnt_d == '0);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= RST_R;
            p_q     <= RST_R;
            busy_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
         end
      end

      assign clk_v[gi]  = clk_q;
      assign tick_v[gi] = tick_q;
      assign busy_v[gi] = busy_q;
   end

   assign bus.clk_out = clk_v;
   assign bus.tick    = tick_v;
   assign bus.busy    = busy_v;
endmodule

// File: doc/iob_clkdiv.md
Name: iob_clkdiv

Overview:
Parametrised multi-channel, glitch-free clock divider for FPGA designs. It generates N_CH divided clocks and matching single-cycle clock-enable ticks from one source clock. Each channel's divide ratio can be reprogrammed at runtime. Each channel's output can be started and stopped at a period boundary. Divided outputs are flop-driven and intended to feed a global clock buffer; ticks serve logic that stays in the source clock domain.

Parameters:
N_CH, 2, number of independent divider channels
DIV_W, 8, width of each channel's divide-ratio field
DIV_RST, 2, divide ratio loaded into every channel at reset (must be >= 2)

Ports:
clk  input  1  source clock
rst  input  1  asynchronous active-high reset
en  input  N_CH  per-channel run enable, level-sensitive
div  input  N_CH*DIV_W  per-channel requested ratio; channel i uses bits [i*DIV_W +: DIV_W]
div_ld  input  N_CH  per-channel one-cycle load strobe for div
clk_out  output  N_CH  divided clocks, registered
tick  output  N_CH  one-cycle pulse on the cycle each divided period starts
busy  output  N_CH  1 while a loaded ratio is pending and not yet applied

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports named clk and rst.
- Channels are fully independent; the rules below apply to each channel i.
- Reset: cnt=0, active ratio R=DIV_RST, pending P=DIV_RST, state IDLE. Outputs clk_out=0, tick=0, busy=0.
- Reset asserted mid-operation forces the reset values immediately (asynchronously), with no period completion.
- Ratio clamp: a loaded div value below 2 is stored as 2. Maximum ratio is 2^DIV_W-1.
- Phases: high phase H = R - floor(R/2) (ceil), low phase L = floor(R/2).
- Counter: in RUN, cnt counts 0..R-1 and wraps to 0.
- Output rules: clk_out=1 iff state==RUN and cnt<H. tick=1 iff state==RUN and cnt==0. Both are registers with no combinational path from inputs.
- State IDLE: clk_out=0, tick=0, cnt held at 0.
  - en=1 sampled at edge t -> at edge t+1 the channel enters RUN with cnt=0, clk_out=1, tick=1.
  - Any pending ratio is applied on this transition.
- State RUN: en is sampled only at the wrap point (cnt==R-1).
  - en=0 at wrap -> IDLE; clk_out stays 0.
  - en=1 at wrap -> new period, cnt=0.
  - Deasserting en mid-period never truncates the period. Reasserting en before the wrap continues with no gap.
- Ratio load: div_ld=1 captures the clamped div into P and sets busy=1 on the next edge.
  - P is applied (R<=P, busy<=0) at the next wrap, or on the IDLE->RUN transition.
  - In IDLE with en=0, P is applied immediately on the following edge and busy clears.
- Repeated load: div_ld while busy overwrites P; last value wins, busy stays 1.
- Simultaneous load and apply: div_ld on the same cycle as an apply edge -> the old P is applied, the new value is captured into P, busy stays 1.
- Glitch-free guarantee: every high phase lasts exactly H and every low phase exactly L of the ratio in force for that period. No runt pulse is ever produced across a ratio change or a stop.
- Latency: ratio change takes effect at most R_old cycles after div_ld. Start latency from en is 1 cycle.

Test Plan:
- Reset release, en=01 (channel 0 only), DIV_RST=2 -> clk_out[0] toggles 1,0,1,0 starting one cycle after en is sampled; tick[0] asserts every 2 cycles; channel 1 stays 0.
- Load div=5 on channel 0 mid-period -> busy=1 until the next wrap; the period then becomes 3 high + 2 low; tick period is 5; no pulse shorter than 1 cycle is seen at the switch.
- Load div=0 and div=1 -> both are clamped to 2: period 2, 1 high + 1 low.
- Deassert en at cnt=1 with R=6 -> the period completes (3 high + 3 low), then clk_out=0 and tick=0. Reassert en -> the period restarts one cycle later with tick.
- Load div=4 then div=7 while busy; on a separate run, issue div_ld on the apply edge -> the first case applies R=7; the second applies the old P while busy stays 1.
- Assert rst while clk_out=1 at R=9 -> clk_out, tick and busy go 0 immediately; after release R=DIV_RST.
